// File: rtl/simon_playback_scheduler.sv
// -----------------------------------------------------------------------------
// simon_playback_scheduler
//
// Plays the stored Simon Says pattern back on the four LEDs. After a start
// request it walks the sequence memory from index 0 up to the latched last
// index. Each step is a dark gap of OFF_TICKS cycles followed by ON_TICKS
// cycles with that step's LED lit. A one-cycle done pulse marks the end of the
// run, and then the block returns to idle.
//
// Ports:
//   i_Clk         system clock
//   i_Rst         asynchronous, active-high reset
//   i_Start       playback request, only looked at while idle
//   i_Abort       cancels a running playback; wins over everything but reset
//   i_Last_Index  index of the final step; clamped to MAX_LEN-1 and latched
//                 when the start is accepted
//   o_Rd_Index    read address into the sequence register file
//   i_Rd_Data     button ID at o_Rd_Index (combinational read)
//   o_LED         one-hot LED drive, all zero while dark
//   o_Busy        high from the cycle after start until the done cycle
//   o_Done        single-cycle completion pulse
//   o_Step        index currently being played (same as o_Rd_Index)
// -----------------------------------------------------------------------------
module simon_playback_scheduler #(
    parameter int CNTS_PER_SEC = 25000000,
    parameter int ON_TICKS     = CNTS_PER_SEC / 4,
    parameter int OFF_TICKS    = CNTS_PER_SEC / 4,
    parameter int MAX_LEN      = 11,
    parameter int IDX_W        = $clog2(MAX_LEN)
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Start,
    input  logic             i_Abort,
    input  logic [IDX_W-1:0] i_Last_Index,
    output logic [IDX_W-1:0] o_Rd_Index,
    input  logic [1:0]       i_Rd_Data,
    output logic [3:0]       o_LED,
    output logic             o_Busy,
    output logic             o_Done,
    output logic [IDX_W-1:0] o_Step
);

    // One shared tick counter serves both phases, so it is sized for the
    // longer of the two.
    localparam int TICK_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int TICK_W   = $clog2(TICK_MAX + 1);

    localparam logic [TICK_W-1:0] ON_LAST  = TICK_W'(ON_TICKS - 1);
    localparam logic [TICK_W-1:0] OFF_LAST = TICK_W'(OFF_TICKS - 1);
    localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(MAX_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        GAP,
        ON,
        DONE
    } state_t;

    state_t            state;
    logic [TICK_W-1:0] tick;
    logic [IDX_W-1:0]  index;
    logic [IDX_W-1:0]  last;
    logic [1:0]        data;

    function automatic logic [3:0] one_hot(input logic [1:0] id);
        one_hot = 4'b0001 << id;
    endfunction

    // The LED is a pure decode of registered state and the captured button
    // ID. The ID is sampled on the last gap cycle so the LED is steady for the
    // whole ON window, whatever the read port does afterwards.
    assign o_LED      = (state == ON) ? one_hot(data) : 4'b0000;
    assign o_Rd_Index = index;
    assign o_Step     = index;

    // Playback sequencer. An abort from any active state drops straight back
    // to idle without a done pulse. The index only advances on the ON->GAP
    // transition, so it can never pass the clamped last index.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state  <= IDLE;
            tick   <= '0;
            index  <= '0;
            last   <= '0;
            data   <= '0;
            o_Busy <= 1'b0;
            o_Done <= 1'b0;
        end else if (i_Abort && (state != IDLE)) begin
            state  <= IDLE;
            tick   <= '0;
            index  <= '0;
            o_Busy <= 1'b0;
            o_Done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_Done <= 1'b0;
                    if (i_Start && !i_Abort) begin
                        state  <= GAP;
                        index  <= '0;
                        tick   <= '0;
                        last   <= (i_Last_Index > IDX_MAX) ? IDX_MAX : i_Last_Index;
                        o_Busy <= 1'b1;
                    end
                end
                GAP: begin
                    if (tick == OFF_LAST) begin
                        data  <= i_Rd_Data;
                        tick  <= '0;
                        state <= ON;
                    end else begin
                        tick <= tick + TICK_W'(1);
                    end
                end
                ON: begin
                    if (tick == ON_LAST) begin
                        tick <= '0;
                        if (index == last) begin
                            state  <= DONE;
                            o_Done <= 1'b1;
                        end else begin
                            index <= index + IDX_W'(1);
                            state <= GAP;
                        end
                    end else begin
                        tick <= tick + TICK_W'(1);
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    o_Done <= 1'b0;
                    o_Busy <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simon_playback_scheduler.sv
// -----------------------------------------------------------------------------
// tb_simon_playback_scheduler
//
// Self-checking bench for simon_playback_scheduler with ON_TICKS=4,
// OFF_TICKS=2, MAX_LEN=11. Every start pushes the full cycle-by-cycle expected
// output trace onto a queue, built from a small reference model of the
// playback. Each cycle after that pops one entry and compares it against the
// DUT outputs at the falling edge.
// -----------------------------------------------------------------------------
module tb_simon_playback_scheduler;

    localparam int ON_T    = 4;
    localparam int OFF_T   = 2;
    localparam int MAXLEN  = 11;
    localparam int IW      = $clog2(MAXLEN);

    logic          i_Clk;
    logic          i_Rst;
    logic          i_Start;
    logic          i_Abort;
    logic [IW-1:0] i_Last_Index;
    logic [IW-1:0] o_Rd_Index;
    logic [1:0]    i_Rd_Data;
    logic [3:0]    o_LED;
    logic          o_Busy;
    logic          o_Done;
    logic [IW-1:0] o_Step;

    logic [1:0] mem [0:15];

    typedef struct {
        logic [3:0]    led;
        logic          busy;
        logic          done;
        logic [IW-1:0] step;
        logic          chkStep;
    } exp_t;

    exp_t expQ [$];

    int checkCount = 0;
    int passCount  = 0;

    simon_playback_scheduler #(
        .CNTS_PER_SEC(16),
        .ON_TICKS    (ON_T),
        .OFF_TICKS   (OFF_T),
        .MAX_LEN     (MAXLEN)
    ) dut (
        .i_Clk       (i_Clk),
        .i_Rst       (i_Rst),
        .i_Start     (i_Start),
        .i_Abort     (i_Abort),
        .i_Last_Index(i_Last_Index),
        .o_Rd_Index  (o_Rd_Index),
        .i_Rd_Data   (i_Rd_Data),
        .o_LED       (o_LED),
        .o_Busy      (o_Busy),
        .o_Done      (o_Done),
        .o_Step      (o_Step)
    );

    // Sequence register file model: combinational read.
    assign i_Rd_Data = mem[o_Rd_Index];

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [3:0] ledFor(input logic [1:0] id);
        case (id)
            2'd0:    ledFor = 4'b0001;
            2'd1:    ledFor = 4'b0010;
            2'd2:    ledFor = 4'b0100;
            default: ledFor = 4'b1000;
        endcase
    endfunction

    // Reference model: push the expected trace of one complete playback,
    // followed by one idle cycle.
    task automatic pushPlayback(input int lastReq);
        int   lastC;
        exp_t e;
        lastC = (lastReq > MAXLEN - 1) ? MAXLEN - 1 : lastReq;
        for (int s = 0; s <= lastC; s++) begin
            for (int g = 0; g < OFF_T; g++) begin
                e = '{led: 4'b0000, busy: 1'b1, done: 1'b0, step: IW'(s), chkStep: 1'b1};
                expQ.push_back(e);
            end
            for (int o = 0; o < ON_T; o++) begin
                e = '{led: ledFor(mem[s]), busy: 1'b1, done: 1'b0, step: IW'(s), chkStep: 1'b1};
                expQ.push_back(e);
            end
        end
        e = '{led: 4'b0000, busy: 1'b1, done: 1'b1, step: IW'(lastC), chkStep: 1'b1};
        expQ.push_back(e);
        e = '{led: 4'b0000, busy: 1'b0, done: 1'b0, step: '0, chkStep: 1'b0};
        expQ.push_back(e);
    endtask

    // Start a playback and check every cycle. A non-negative abortAt raises
    // i_Abort during that trace cycle; startPulseAt re-pulses i_Start
    // mid-playback.
    task automatic applyStimulus(input int lastReq, input int abortAt,
                                 input int startPulseAt, input string name);
        int   n;
        exp_t e;
        pushPlayback(lastReq);
        i_Last_Index = IW'(lastReq);
        i_Start      = 1'b1;
        n            = 0;
        while (expQ.size() > 0) begin
            @(negedge i_Clk);
            i_Start = 1'b0;
            i_Abort = 1'b0;
            e = expQ.pop_front();
            checkOutput($sformatf("%s c%0d led", name, n), 32'(o_LED), 32'(e.led));
            checkOutput($sformatf("%s c%0d busy", name, n), 32'(o_Busy), 32'(e.busy));
            checkOutput($sformatf("%s c%0d done", name, n), 32'(o_Done), 32'(e.done));
            if (e.chkStep) begin
                checkOutput($sformatf("%s c%0d step", name, n), 32'(o_Step), 32'(e.step));
                checkOutput($sformatf("%s c%0d rdidx", name, n), 32'(o_Rd_Index), 32'(e.step));
            end
            if (n == startPulseAt) i_Start = 1'b1;
            if (n == abortAt) begin
                i_Abort = 1'b1;
                expQ.delete();
            end
            n++;
        end
        if (abortAt >= 0) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge i_Clk);
                i_Abort = 1'b0;
                checkOutput($sformatf("%s abort%0d led", name, k), 32'(o_LED), 32'd0);
                checkOutput($sformatf("%s abort%0d busy", name, k), 32'(o_Busy), 32'd0);
                checkOutput($sformatf("%s abort%0d done", name, k), 32'(o_Done), 32'd0);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 2'd0;
        i_Rst        = 1'b1;
        i_Start      = 1'b0;
        i_Abort      = 1'b0;
        i_Last_Index = '0;

        // Reset state
        #1;
        checkOutput("reset led", 32'(o_LED), 32'd0);
        checkOutput("reset busy", 32'(o_Busy), 32'd0);
        checkOutput("reset done", 32'(o_Done), 32'd0);
        checkOutput("reset rdidx", 32'(o_Rd_Index), 32'd0);
        repeat (2) @(negedge i_Clk);
        i_Rst = 1'b0;
        @(negedge i_Clk);

        // Single step, ID 2
        mem[0] = 2'd2;
        applyStimulus(0, -1, -1, "single");

        // Three steps {3,0,1}
        mem[0] = 2'd3; mem[1] = 2'd0; mem[2] = 2'd1;
        applyStimulus(2, -1, -1, "three");

        // Abort on the second cycle of step-1 ON, then a clean replay
        applyStimulus(2, 9, -1, "abort");
        applyStimulus(2, -1, -1, "replay");

        // Mid-playback start is ignored
        applyStimulus(2, -1, 7, "midstart");

        // Start and abort together in idle
        i_Start = 1'b1;
        i_Abort = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_Clk);
            checkOutput($sformatf("startabort%0d busy", k), 32'(o_Busy), 32'd0);
            checkOutput($sformatf("startabort%0d led", k), 32'(o_LED), 32'd0);
        end
        i_Start = 1'b0;
        i_Abort = 1'b0;
        @(negedge i_Clk);

        // Last index beyond memory depth clamps to MAX_LEN-1
        for (int i = 0; i < 16; i++) mem[i] = 2'($urandom_range(0, 3));
        applyStimulus(15, -1, -1, "clamp");

        // Asynchronous reset in the middle of step-1 ON
        mem[0] = 2'd3; mem[1] = 2'd0; mem[2] = 2'd1;
        i_Last_Index = IW'(2);
        i_Start      = 1'b1;
        @(negedge i_Clk);
        i_Start = 1'b0;
        repeat (8) @(negedge i_Clk);
        checkOutput("prereset led", 32'(o_LED), 32'b0001);
        checkOutput("prereset rdidx", 32'(o_Rd_Index), 32'd1);
        @(posedge i_Clk);
        #2 i_Rst = 1'b1;
        #1;
        checkOutput("asyncrst led", 32'(o_LED), 32'd0);
        checkOutput("asyncrst busy", 32'(o_Busy), 32'd0);
        checkOutput("asyncrst done", 32'(o_Done), 32'd0);
        checkOutput("asyncrst rdidx", 32'(o_Rd_Index), 32'd0);
        @(negedge i_Clk);
        i_Rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge i_Clk);
            checkOutput($sformatf("postrst%0d busy", k), 32'(o_Busy), 32'd0);
            checkOutput($sformatf("postrst%0d led", k), 32'(o_LED), 32'd0);
            checkOutput($sformatf("postrst%0d done", k), 32'(o_Done), 32'd0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
